// File: rtl/ece552_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ece552_pkg
// Description : Shared constants, access-size encodings and controller FSM
//               state encoding for the data-memory controller.
// Revision    : 1.0 - initial release
// ============================================================================
package ece552_pkg;

  localparam int XLEN = 32;

  // Access-size encodings carried on i_req_size
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/dmem_lane_align.sv
`default_nettype none
// ============================================================================
// Module      : dmem_lane_align
// Description : Combinational byte-lane helper. From the byte offset, access
//               size and signedness it produces the store lane mask, the
//               store data shifted onto its lanes, the extracted/extended
//               load data and a flag for misaligned or reserved-size access.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_lane_align
  import ece552_pkg::*;
(
  input  logic [1:0]      i_off,
  input  logic [1:0]      i_size,
  input  logic            i_unsigned,
  input  logic [XLEN-1:0] i_wdata,
  input  logic [XLEN-1:0] i_rword,
  output logic [3:0]      o_mask,
  output logic [XLEN-1:0] o_wshift,
  output logic [XLEN-1:0] o_rdata,
  output logic            o_misalign
);

  logic [XLEN-1:0] w_raw;
  logic [4:0]      w_shamt;

  // Lane mask, store shift and load extract/extend for the selected size
  always_comb begin
    w_shamt    = {i_off, 3'b000};
    w_raw      = i_rword >> w_shamt;
    o_wshift   = i_wdata << w_shamt;
    o_mask     = 4'b0000;
    o_rdata    = '0;
    o_misalign = 1'b0;
    case (i_size)
      SZ_BYTE: begin
        o_mask  = 4'b0001 << i_off;
        o_rdata = i_unsigned ? {{(XLEN-8){1'b0}}, w_raw[7:0]}
                             : {{(XLEN-8){w_raw[7]}}, w_raw[7:0]};
      end
      SZ_HALF: begin
        // A half at offset 3 would straddle words; offset 1 is also illegal.
        o_misalign = i_off[0];
        o_mask     = 4'b0011 << i_off;
        o_rdata    = i_unsigned ? {{(XLEN-16){1'b0}}, w_raw[15:0]}
                                : {{(XLEN-16){w_raw[15]}}, w_raw[15:0]};
      end
      SZ_WORD: begin
        o_misalign = (i_off != 2'b00);
        o_mask     = 4'b1111;
        o_rdata    = w_raw;
      end
      default: begin
        // Reserved size is reported through the same error path.
        o_misalign = 1'b1;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/dmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dmem_ctrl
// Description : Data-memory controller with a valid/ready request/response
//               interface, one outstanding request and a fixed programmable
//               access latency. Supports byte/half/word loads and stores
//               with sign/zero extension; flags misaligned, reserved-size and
//               out-of-range accesses without touching the array.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_ctrl
  import ece552_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_req_valid,
  output logic            o_req_ready,
  input  logic            i_req_write,
  input  logic [31:0]     i_req_addr,
  input  logic [1:0]      i_req_size,
  input  logic            i_req_unsigned,
  input  logic [31:0]     i_req_wdata,
  output logic            o_rsp_valid,
  input  logic            i_rsp_ready,
  output logic [31:0]     o_rsp_rdata,
  output logic            o_rsp_err,
  output logic            o_busy
);

  localparam int         IDXW     = $clog2(DEPTH);
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  // Storage array; deliberately has no reset so contents survive rst.
  logic [XLEN-1:0] mem [DEPTH];

  state_e          state_q,    state_d;
  logic [3:0]      cnt_q,      cnt_d;
  logic            write_q,    write_d;
  logic [31:0]     addr_q,     addr_d;
  logic [1:0]      size_q,     size_d;
  logic            unsigned_q, unsigned_d;
  logic [31:0]     wdata_q,    wdata_d;
  logic [31:0]     rdata_q,    rdata_d;
  logic            err_q,      err_d;

  logic [IDXW-1:0] w_idx;
  logic [XLEN-1:0] w_rword;
  logic [3:0]      w_mask;
  logic [XLEN-1:0] w_wshift;
  logic [XLEN-1:0] w_rdata;
  logic            w_misalign;
  logic            w_oor;
  logic            w_err;
  logic            w_access;
  logic            w_do_write;

  // Address decode, range check and access qualification on latched request
  always_comb begin
    w_idx      = addr_q[IDXW+1:2];
    w_rword    = mem[w_idx];
    w_oor      = (addr_q[31:2] >= 30'(DEPTH));
    w_err      = w_misalign | w_oor;
    w_access   = (state_q == ST_WAIT) && (cnt_q == 4'd0);
    w_do_write = w_access && write_q && !w_err;
  end

  dmem_lane_align u_align (
    .i_off      (addr_q[1:0]),
    .i_size     (size_q),
    .i_unsigned (unsigned_q),
    .i_wdata    (wdata_q),
    .i_rword    (w_rword),
    .o_mask     (w_mask),
    .o_wshift   (w_wshift),
    .o_rdata    (w_rdata),
    .o_misalign (w_misalign)
  );

  // Next-state, counter, request latch and response register logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    write_d    = write_q;
    addr_d     = addr_q;
    size_d     = size_q;
    unsigned_d = unsigned_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    case (state_q)
      ST_IDLE: begin
        if (i_req_valid) begin
          write_d    = i_req_write;
          addr_d     = i_req_addr;
          size_d     = i_req_size;
          unsigned_d = i_req_unsigned;
          wdata_d    = i_req_wdata;
          cnt_d      = CNT_LOAD;
          state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          err_d   = w_err;
          rdata_d = (w_err || write_q) ? '0 : w_rdata;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        // Returning to IDLE here means the next accept is one cycle later.
        if (i_rsp_ready) begin
          rdata_d = '0;
          err_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and request/response registers with synchronous active-low reset
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      write_q    <= 1'b0;
      addr_q     <= '0;
      size_q     <= SZ_BYTE;
      unsigned_q <= 1'b0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      write_q    <= write_d;
      addr_q     <= addr_d;
      size_q     <= size_d;
      unsigned_q <= unsigned_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

  // Masked byte-lane store at the WAIT-exit edge; reset discards it
  always_ff @(posedge i_clk) begin
    if (i_rst_n && w_do_write) begin
      for (int b = 0; b < 4; b++) begin
        if (w_mask[b]) begin
          mem[w_idx][8*b +: 8] <= w_wshift[8*b +: 8];
        end
      end
    end
  end

  // Handshake and status outputs decoded from state
  always_comb begin
    o_req_ready = (state_q == ST_IDLE);
    o_busy      = (state_q != ST_IDLE);
    o_rsp_valid = (state_q == ST_RESP);
    o_rsp_rdata = rdata_q;
    o_rsp_err   = err_q;
  end

endmodule
`default_nettype wire
